unified_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-ported unified instruction/data memory between the instruction-fetch requester and the load/store (data) requester. It registers one request at a time, drives the memory command for one cycle, captures the synchronous read data and returns a one-cycle response pulse to the winning requester. Data accesses are relocated into the data half of memory by a fixed base offset. A starvation counter keeps fetch from being locked out by back-to-back loads and stores.

---
 rtl/unified_mem_arbiter_if.sv | 60 ++++++
 rtl/unified_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the unified memory arbiter, its two requesters
// (instruction fetch and load/store) and the single-ported memory.
//
// Handshake rules, shared by both requester ports:
//   A request is accepted on a rising edge where req && ready are both high.
//   The requester holds req and its command fields stable until then.
//   After acceptance the fields may change freely.
//   valid pulses for exactly one cycle per accepted request, with err and
//   rdata qualified by it. The memory side gets a one-cycle mem_en strobe,
//   and read data comes back on mem_rdata in the following cycle.
//
// Modports:
//   slave  - the arbiter. It receives requests, drives ready/valid/rdata/err,
//            drives the memory command and receives mem_rdata.
//   master - the environment: the requesters and the memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_valid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [2:0]        d_func3;
  logic              d_ready;
  logic              d_valid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_func3;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ready, if_valid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_func3,
    output d_ready, d_valid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_func3,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ready, if_valid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_func3,
    input  d_ready, d_valid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_func3,
    output mem_rdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and
// load/store. It accepts one request at a time and issues a one-cycle memory
// command. It captures the synchronous read data and returns a one-cycle
// response pulse to the owning requester. Data addresses are relocated by
// DATA_BASE. A starvation counter guarantees fetch a grant after STARVE_MAX
// consecutive losses to data.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   bus (slave)     - fetch port, data port and memory command/read data
//   dbg_state       - current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   dbg_starve_cnt  - current starvation count, zero-extended
module unified_mem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_BASE  = 256,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus,
  output logic [1:0]            dbg_state,
  output logic [7:0]            dbg_starve_cnt
);

  localparam int                SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(DATA_BASE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              owner_d_q, owner_d_d;   // 1 = data port owns the access
  logic              load_q, load_d;         // response updates rdata
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_func3_q, mem_func3_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  logic              can_accept;
  logic              fetch_wins;
  logic              if_ready;
  logic              d_ready;
  logic              if_acc;
  logic              d_acc;
  logic              if_mis;
  logic              d_mis;
  logic [ADDR_W-1:0] d_phys;

  // Alignment is judged on the requester address. DATA_BASE is word aligned,
  // so the relocated address has the same low bits.
  always_comb begin
    if_mis = |bus.if_addr[1:0];
    case (bus.d_func3)
      3'b010:         d_mis = |bus.d_addr[1:0];
      3'b001, 3'b101: d_mis = bus.d_addr[0];
      default:        d_mis = 1'b0;
    endcase
  end

  // Data wins by default. Fetch wins when it is the only requester, or when
  // it has already lost STARVE_MAX times in a row.
  always_comb begin
    can_accept = (state_q == IDLE) || (state_q == RESP);
    fetch_wins = bus.if_req && (!bus.d_req || (starve_q == STARVE_TOP));
    if_ready   = can_accept && fetch_wins;
    d_ready    = can_accept && bus.d_req && !fetch_wins;
    if_acc     = bus.if_req && if_ready;
    d_acc      = bus.d_req && d_ready;
    d_phys     = bus.d_addr + BASE;   // wraps silently modulo 2^ADDR_W
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d_d   = owner_d_q;
    load_d      = load_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_func3_d = mem_func3_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ISSUE: state_d = WAIT;
      WAIT: begin
        // The memory returns data in this cycle. The response pulse appears
        // with it in RESP because the outputs are registered here.
        state_d = RESP;
        if (owner_d_q) begin
          d_valid_d = 1'b1;
          if (load_q) d_rdata_d = bus.mem_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end
      end
      default: state_d = IDLE;  // IDLE and RESP; an accept below overrides
    endcase

    if (if_acc) begin
      starve_d  = '0;
      owner_d_d = 1'b0;
      load_d    = 1'b1;
      if (if_mis) begin
        state_d    = RESP;
        if_valid_d = 1'b1;
        if_err_d   = 1'b1;
      end else begin
        state_d     = ISSUE;
        mem_en_d    = 1'b1;
        mem_addr_d  = bus.if_addr;
        mem_func3_d = 3'b010;
      end
    end else if (d_acc) begin
      if (bus.if_req && (starve_q != STARVE_TOP)) starve_d = starve_q + SW'(1);
      owner_d_d = 1'b1;
      load_d    = !bus.d_we;
      if (d_mis) begin
        state_d   = RESP;
        d_valid_d = 1'b1;
        d_err_d   = 1'b1;
      end else begin
        state_d     = ISSUE;
        mem_en_d    = 1'b1;
        mem_we_d    = bus.d_we;
        mem_addr_d  = d_phys;
        mem_wdata_d = bus.d_wdata;
        mem_func3_d = bus.d_func3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_d_q   <= 1'b0;
      load_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_func3_q <= '0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_d_q   <= owner_d_d;
      load_q      <= load_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_func3_q <= mem_func3_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_ready   = if_ready;
  assign bus.if_valid   = if_valid_q;
  assign bus.if_err     = if_err_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_ready    = d_ready;
  assign bus.d_valid    = d_valid_q;
  assign bus.d_err      = d_err_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_func3  = mem_func3_q;

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = 8'(starve_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed steps followed by
// random single transactions. Each one is checked against a reference built
// from the access rules. The reference covers relocation, alignment, latency,
// word memory contents and the starvation pattern.
module tb_unified_mem_arbiter;
  localparam int ADDR_W     = 9;
  localparam int DATA_BASE  = 256;
  localparam int STARVE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  logic [7:0] dbg_starve_cnt;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_BASE(DATA_BASE), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- memory environment and reference ----------------
  logic [31:0] mem       [0:127];
  logic [31:0] init_mem  [0:127];
  logic [31:0] model_mem [0:127];
  logic        load_mem;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (load_mem) begin
      mem <= init_mem;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_misaligned(input bit fetch, input logic [8:0] a, input logic [2:0] f3);
    int ai = int'(a);
    if (fetch) return (ai % 4) != 0;
    if (f3 == 3'd2) return (ai % 4) != 0;
    if (f3 == 3'd1 || f3 == 3'd5) return (ai % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [8:0] ref_phys(input bit fetch, input logic [8:0] a);
    if (fetch) return a;
    return 9'((int'(a) + DATA_BASE) % 512);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge with the arbiter idle. Returns at a falling edge.
  task automatic run_txn(input bit fetch, input bit we, input logic [8:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    bit          mis;
    logic [8:0]  pa;
    logic [31:0] exp_rd;
    mis = ref_misaligned(fetch, addr, f3);
    pa  = ref_phys(fetch, addr);
    if (fetch) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_func3 = f3;
    end
    #1;
    check("ready_own",   32'(fetch ? bus.if_ready : bus.d_ready), 32'd1);
    check("ready_other", 32'(fetch ? bus.d_ready : bus.if_ready), 32'd0);
    @(posedge clk); #1;
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.if_addr = 9'($urandom);
    bus.d_addr  = 9'($urandom);
    bus.d_wdata = $urandom;
    bus.d_we    = 1'($urandom);
    bus.d_func3 = 3'($urandom);
    @(negedge clk);
    if (mis) begin
      check("mis_mem_en", 32'(bus.mem_en), 32'd0);
      check("mis_valid", 32'(fetch ? bus.if_valid : bus.d_valid), 32'd1);
      check("mis_err",   32'(fetch ? bus.if_err : bus.d_err), 32'd1);
      check("mis_rdata", fetch ? bus.if_rdata : bus.d_rdata, fetch ? exp_if_rdata : exp_d_rdata);
    end else begin
      check("c1_mem_en",    32'(bus.mem_en), 32'd1);
      check("c1_mem_addr",  32'(bus.mem_addr), 32'(pa));
      check("c1_mem_we",    32'(bus.mem_we), 32'(!fetch && we));
      check("c1_mem_func3", 32'(bus.mem_func3), fetch ? 32'd2 : 32'(f3));
      if (!fetch && we) check("c1_mem_wdata", bus.mem_wdata, wdata);
      check("c1_valid", 32'(fetch ? bus.if_valid : bus.d_valid), 32'd0);
      exp_rd = model_mem[pa[8:2]];
      if (!fetch && we) model_mem[pa[8:2]] = wdata;
      @(negedge clk);
      check("c2_mem_en", 32'(bus.mem_en), 32'd0);
      check("c2_valid",  32'(fetch ? bus.if_valid : bus.d_valid), 32'd0);
      @(negedge clk);
      if (fetch) exp_if_rdata = exp_rd;
      else if (!we) exp_d_rdata = exp_rd;
      check("c3_valid", 32'(fetch ? bus.if_valid : bus.d_valid), 32'd1);
      check("c3_err",   32'(fetch ? bus.if_err : bus.d_err), 32'd0);
      check("c3_rdata", fetch ? bus.if_rdata : bus.d_rdata, fetch ? exp_if_rdata : exp_d_rdata);
    end
    @(negedge clk);
    check("post_if_valid", 32'(bus.if_valid), 32'd0);
    check("post_d_valid",  32'(bus.d_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
    check({tag, "_d_valid"},   32'(bus.d_valid), 32'd0);
    check({tag, "_if_err"},    32'(bus.if_err), 32'd0);
    check({tag, "_d_err"},     32'(bus.d_err), 32'd0);
    check({tag, "_if_rdata"},  bus.if_rdata, 32'd0);
    check({tag, "_d_rdata"},   bus.d_rdata, 32'd0);
    check({tag, "_mem_en"},    32'(bus.mem_en), 32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    check({tag, "_mem_func3"}, 32'(bus.mem_func3), 32'd0);
    check({tag, "_state"},     32'(dbg_state), 32'd0);
    check({tag, "_starve"},    32'(dbg_starve_cnt), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    int          ms;
    bit          chk_starve;
    logic [8:0]  a;
    bit          f;
    bit          w;

    rst = 1'b1; load_mem = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_func3 = '0;
    for (int i = 0; i < 128; i++) init_mem[i] = $urandom;
    init_mem[2] = 32'h01592E33;
    for (int i = 0; i < 128; i++) model_mem[i] = init_mem[i];
    exp_if_rdata = '0;
    exp_d_rdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_ready_if", 32'(bus.if_ready), 32'd0);
    check("reset_ready_d",  32'(bus.d_ready), 32'd0);
    rst = 1'b0; load_mem = 1'b0;
    @(negedge clk);

    // Aligned fetch of a known word
    run_txn(1'b1, 1'b0, 9'h008, 32'h0, 3'b010);
    check("fetch_word", exp_if_rdata, 32'h01592E33);

    // Store then load through the data window
    run_txn(1'b0, 1'b1, 9'h00C, 32'hDEADBEEF, 3'b010);
    run_txn(1'b0, 1'b0, 9'h00C, 32'h0, 3'b010);
    check("store_load_word", exp_d_rdata, 32'hDEADBEEF);

    // Alignment cases: lw misaligned, lh misaligned, lb aligned to 0x103
    run_txn(1'b0, 1'b0, 9'h002, 32'h0, 3'b010);
    run_txn(1'b0, 1'b0, 9'h003, 32'h0, 3'b001);
    run_txn(1'b0, 1'b0, 9'h003, 32'h0, 3'b000);
    run_txn(1'b1, 1'b0, 9'h006, 32'h0, 3'b010);

    // Starvation: both requesters held high
    check("starve_start", 32'(dbg_starve_cnt), 32'd0);
    ms = 0;
    for (int k = 0; k < 8; k++) begin
      if (ms == STARVE_MAX) begin exp_q.push_back(32'd1); ms = 0; end
      else begin exp_q.push_back(32'd0); ms++; end
    end
    bus.if_req = 1'b1; bus.if_addr = 9'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h020; bus.d_func3 = 3'b010;
    chk_starve = 1'b0;
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      #1;
      if (chk_starve) begin
        check("starve_clear", 32'(dbg_starve_cnt), 32'd0);
        chk_starve = 1'b0;
      end
      if (bus.if_ready || bus.d_ready) begin
        check("one_ready", 32'(bus.if_ready && bus.d_ready), 32'd0);
        chk_starve = bus.if_ready;
        check("winner", 32'(bus.if_ready), exp_q.pop_front());
      end
      @(negedge clk);
    end
    #1;
    if (chk_starve) check("starve_clear", 32'(dbg_starve_cnt), 32'd0);
    check("starve_pending", 32'(exp_q.size()), 32'd0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (5) @(negedge clk);
    exp_if_rdata = model_mem[4];
    exp_d_rdata  = model_mem[(32'h020 + DATA_BASE) / 4];

    // Random single transactions
    for (int n = 0; n < 40; n++) begin
      f = 1'($urandom_range(0, 1));
      w = f ? 1'b0 : 1'($urandom_range(0, 1));
      a = 9'($urandom_range(0, 127) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 9'($urandom_range(1, 3));
      run_txn(f, w, a, $urandom, 3'($urandom_range(0, 7)));
    end

    // Wrap-around, then reset while the load sits in WAIT
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 9'h1FC; bus.d_func3 = 3'b010;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("wrap_mem_en",   32'(bus.mem_en), 32'd1);
    check("wrap_mem_addr", 32'(bus.mem_addr), 32'h0FC);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(bus.d_valid), 32'd0);
    end
    exp_if_rdata = '0;
    exp_d_rdata  = '0;

    // Reset on the accepting edge of a store: nothing reaches memory
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 9'h040;
    bus.d_wdata = 32'hCAFEF00D; bus.d_func3 = 3'b010;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(negedge clk);
    check("rststore_mem_en", 32'(bus.mem_en), 32'd0);
    check("rststore_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 1'b0, 9'h040, 32'h0, 3'b010);

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
